// File: rtl/reset_sequencer_if.sv
// Reset sequencer side-band bundle: PLL lock and soft-reset requests in, staged resets out.
// The sequencer drives the master modport; the consumer/stimulus side uses slave.
interface reset_sequencer_if;
    logic pll_lock;
    logic soft_rst;
    logic fabric_reset_n;
    logic periph_reset_n;
    logic ready;
    logic lock_lost;

    modport master (
        input  pll_lock,
        input  soft_rst,
        output fabric_reset_n,
        output periph_reset_n,
        output ready,
        output lock_lost
    );

    modport slave (
        output pll_lock,
        output soft_rst,
        input  fabric_reset_n,
        input  periph_reset_n,
        input  ready,
        input  lock_lost
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: qualifies PLL lock, then releases the fabric reset and later the
// peripheral reset; re-sequences on lock loss or a soft reset request.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned STAGE_DELAY = 32,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    reset_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        StReset,
        StWaitLock,
        StDlyFab,
        StDlyPer,
        StRun
    } state_e;

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] DlyLast  = CNT_W'(STAGE_DELAY - 1);

    // The state register acts as the last reset-release stage, so the chain is one flop short.
    logic [SYNC_STAGES-2:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   rst_sync_n;
    logic                   lock_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fab_q, fab_d;
    logic             per_q, per_d;
    logic             rdy_q, rdy_d;
    logic             lost_q, lost_d;
    logic             restart;

    always_comb begin
        rst_sync_d[0] = 1'b1;
        for (int i = 1; i < SYNC_STAGES - 1; i++) begin
            rst_sync_d[i] = rst_sync_q[i-1];
        end
        lock_sync_d[0] = bus.pll_lock;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            lock_sync_d[i] = lock_sync_q[i-1];
        end
    end

    assign rst_sync_n = rst_sync_q[SYNC_STAGES-2];
    assign lock_s     = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fab_d   = fab_q;
        per_d   = per_q;
        rdy_d   = rdy_q;
        lost_d  = lost_q;
        restart = 1'b0;

        unique case (state_q)
            StReset: begin
                if (rst_sync_n) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    cnt_d   = '0;
                    state_d = StDlyFab;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDlyFab: begin
                if (cnt_q == DlyLast) begin
                    fab_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StDlyPer;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDlyPer: begin
                if (cnt_q == DlyLast) begin
                    per_d   = 1'b1;
                    rdy_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
            end
            default: begin
                state_d = StReset;
                cnt_d   = '0;
            end
        endcase

        // Restart overrides any sequencing step scheduled for the same edge.
        if (state_q != StReset) begin
            restart = bus.soft_rst || (!lock_s && state_q != StWaitLock);
        end
        if (restart) begin
            state_d = StWaitLock;
            cnt_d   = '0;
            fab_d   = 1'b0;
            per_d   = 1'b0;
            rdy_d   = 1'b0;
            if (state_q == StRun && !lock_s) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
            state_q     <= StReset;
            cnt_q       <= '0;
            fab_q       <= 1'b0;
            per_q       <= 1'b0;
            rdy_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fab_q       <= fab_d;
            per_q       <= per_d;
            rdy_q       <= rdy_d;
            lost_q      <= lost_d;
        end
    end

    assign bus.fabric_reset_n = fab_q;
    assign bus.periph_reset_n = per_q;
    assign bus.ready          = rdy_q;
    assign bus.lock_lost      = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, lock glitch, lock loss, soft reset
// and mid-sequence reset, plus a per-cycle release-ordering check.
module tb_reset_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   edge_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .SYNC_STAGES (2),
        .LOCK_FILTER (16),
        .STAGE_DELAY (32),
        .CNT_W       (16)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Edge 1 is the first rising edge with reset released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Packed as {fabric_reset_n, periph_reset_n, ready, lock_lost}.
    task automatic check_outs(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'b0, bus.fabric_reset_n, bus.periph_reset_n, bus.ready, bus.lock_lost},
                 {28'b0, exp});
    endtask

    task automatic run_to(input int k);
        int guard = 0;
        while (edge_n < k && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != k) check_eq("run_to_timeout", edge_n, k);
    endtask

    always @(negedge clk) begin
        check_eq("order", {30'b0, bus.periph_reset_n & ~bus.fabric_reset_n,
                           bus.ready ^ bus.periph_reset_n}, 32'd0);
    end

    initial begin
        bus.pll_lock = 1'b1;
        bus.soft_rst = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("reset_state", 4'b0000);
        rst_n = 1'b1;

        // Lock steady high: fabric at 50, peripherals/ready at 82.
        run_to(49);  check_outs("t1_pre_fab", 4'b0000);
        run_to(50);  check_outs("t1_fab",     4'b1000);
        run_to(81);  check_outs("t1_pre_per", 4'b1000);
        run_to(82);  check_outs("t1_per",     4'b1110);

        // Lock drop in run for 3 cycles.
        run_to(90);  bus.pll_lock = 1'b0;
        run_to(92);  check_outs("t3_pre_drop", 4'b1110);
        run_to(93);  check_outs("t3_drop",     4'b0001);
        bus.pll_lock = 1'b1;
        run_to(142); check_outs("t3_pre_fab",  4'b0001);
        run_to(143); check_outs("t3_fab",      4'b1001);
        run_to(160); check_outs("t3_mid",      4'b1001);

        // Asynchronous reset mid-sequence.
        rst_n = 1'b0;
        #1 check_outs("t5_async", 4'b0000);
        repeat (2) @(negedge clk);
        check_outs("t5_held", 4'b0000);
        rst_n = 1'b1;
        run_to(49);  check_outs("t5_pre_fab", 4'b0000);
        run_to(50);  check_outs("t5_fab",     4'b1000);

        // Soft reset during peripheral delay.
        run_to(60);  check_outs("t4_pre_soft", 4'b1000);
        bus.soft_rst = 1'b1;
        run_to(61);  check_outs("t4_soft",     4'b0000);
        bus.soft_rst = 1'b0;
        run_to(108); check_outs("t4_pre_fab",  4'b0000);
        run_to(109); check_outs("t4_fab",      4'b1000);
        run_to(140); check_outs("t4_pre_per",  4'b1000);
        run_to(141); check_outs("t4_per",      4'b1110);

        // Late lock with a one-cycle glitch: fabric 50 edges after final rise at 38.
        rst_n = 1'b0;
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_to(30);  bus.pll_lock = 1'b1;
        run_to(37);  bus.pll_lock = 1'b0;
        run_to(38);  bus.pll_lock = 1'b1;
        run_to(80);  check_outs("t2_glitch_held", 4'b0000);
        run_to(87);  check_outs("t2_pre_fab",     4'b0000);
        run_to(88);  check_outs("t2_fab",         4'b1000);
        run_to(119); check_outs("t2_pre_per",     4'b1000);
        run_to(120); check_outs("t2_per",         4'b1110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
